// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 16;

endpackage

// File: rtl/seq_divider_if.sv
// Operand and result handshake bundle for seq_divider.
interface seq_divider_if import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             src_valid;
  logic             src_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             dest_valid;
  logic             dest_ready;

  modport master (
    output dividend, divisor, src_valid, dest_ready,
    input  src_ready, quotient, remainder, div_by_zero, dest_valid
  );

  modport slave (
    input  dividend, divisor, src_valid, dest_ready,
    output src_ready, quotient, remainder, div_by_zero, dest_valid
  );

endinterface

// File: rtl/div_datapath.sv
// Restoring-division datapath: magnitude/sign capture, R/Q shifting, iteration
// counter and sign fix-up into the output registers.
module div_datapath import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fix,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_count_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH:0]   r_mag_b;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH:0]   w_ext_b;
  logic [WIDTH:0]   w_abs_b;
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH+1:0] w_trial;
  logic             w_trial_ok;
  logic [WIDTH-1:0] w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;
  logic             w_dbz;
  logic             w_unused;

  // |dividend| fits WIDTH bits read as unsigned, even for the most negative value
  assign w_abs_a     = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_ext_b     = {i_divisor[WIDTH-1], i_divisor};
  assign w_abs_b     = w_ext_b[WIDTH] ? -w_ext_b : w_ext_b;
  assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = {1'b0, w_shift_rem} - {1'b0, r_mag_b};
  assign w_trial_ok  = ~w_trial[WIDTH+1];
  assign w_unused    = w_trial[WIDTH];

  assign o_count_done  = (r_count == CW'(WIDTH - 1));
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag_b  <= {(WIDTH+1){1'b0}};
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_quo    <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_load) begin
      r_mag_b  <= w_abs_b;
      r_sign_a <= i_dividend[WIDTH-1];
      r_sign_b <= i_divisor[WIDTH-1];
      r_quo    <= w_abs_a;
      r_rem    <= {WIDTH{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_step) begin
      r_rem   <= w_trial_ok ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
      r_quo   <= {r_quo[WIDTH-2:0], w_trial_ok};
      r_count <= r_count + CW'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  // With a zero divisor every trial succeeds, so R ends as |dividend| and the
  // ordinary remainder fix-up already reproduces the dividend.
  always_comb begin
    w_dbz     = 1'b0;
    w_fix_rem = r_sign_a ? -r_rem : r_rem;
    w_fix_quo = r_quo;
    if (r_mag_b == {(WIDTH+1){1'b0}}) begin
      w_dbz     = 1'b1;
      w_fix_quo = {WIDTH{1'b1}};
    end else begin
      w_dbz     = 1'b0;
      w_fix_quo = (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quotient    <= {WIDTH{1'b0}};
      r_remainder   <= {WIDTH{1'b0}};
      r_div_by_zero <= 1'b0;
    end else if (i_fix) begin
      r_quotient    <= w_fix_quo;
      r_remainder   <= w_fix_rem;
      r_div_by_zero <= w_dbz;
    end else if (i_clear) begin
      r_div_by_zero <= 1'b0;
    end else begin
      r_div_by_zero <= r_div_by_zero;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: handshake FSM around a one-bit-per-cycle
// restoring datapath with a final sign fix-up.
module seq_divider import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  div_state_t r_state;
  div_state_t w_next_state;
  logic       w_load;
  logic       w_step;
  logic       w_fix;
  logic       w_clear;
  logic       w_count_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.src_valid) begin
          w_load       = 1'b1;
          w_next_state = CALC;
        end else begin
          w_next_state = IDLE;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_count_done) begin
          w_next_state = FIX;
        end else begin
          w_next_state = CALC;
        end
      end
      FIX: begin
        w_fix        = 1'b1;
        w_next_state = DONE;
      end
      DONE: begin
        if (bus.dest_ready) begin
          w_clear      = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // src_ready is held low while rst is asserted so no operand is accepted in reset
  assign bus.src_ready  = (r_state == IDLE) & ~rst;
  assign bus.dest_valid = (r_state == DONE);

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_fix         (w_fix),
    .i_clear       (w_clear),
    .i_dividend    (bus.dividend),
    .i_divisor     (bus.divisor),
    .o_count_done  (w_count_done),
    .o_quotient    (bus.quotient),
    .o_remainder   (bus.remainder),
    .o_div_by_zero (bus.div_by_zero)
  );

endmodule
